// File: rtl/wvb_arb_pkg.sv
// Shared definitions for the waveform-buffer readout arbiter.
//   arb_state_e       : FSM state encoding (IDLE/OFFER/ACTIVE/HOLDOFF)
//   P_CHAN_WIDTH_DEF  : default channel-index width
//   MAX_CHANNELS      : upper bound on channel count
//   idx_to_onehot()   : channel index -> MAX_CHANNELS-wide one-hot
package wvb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_HOLDOFF = 2'd3
  } arb_state_e;

  localparam int P_CHAN_WIDTH_DEF = 5;
  localparam int MAX_CHANNELS     = 32;

  // Indices at or beyond MAX_CHANNELS yield all zeros.
  function automatic logic [MAX_CHANNELS-1:0] idx_to_onehot(input int unsigned idx);
    logic [MAX_CHANNELS-1:0] oh;
    oh = '0;
    if (idx < MAX_CHANNELS) oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wvb_rdout_arbiter_rr_priority_select.sv
// rr_priority_select: combinational round-robin pick.
//   req      in  N_CHANNELS    request vector
//   last_ptr in  P_CHAN_WIDTH  most recently served channel
//   found    out 1             any request present
//   next_idx out P_CHAN_WIDTH  first requester strictly after last_ptr (cyclic)
module rr_priority_select
  import wvb_arb_pkg::*;
#(
  parameter int N_CHANNELS   = 24,
  parameter int P_CHAN_WIDTH = P_CHAN_WIDTH_DEF
) (
  input  logic [N_CHANNELS-1:0]   req,
  input  logic [P_CHAN_WIDTH-1:0] last_ptr,
  output logic                    found,
  output logic [P_CHAN_WIDTH-1:0] next_idx
);

  int unsigned             start;
  int unsigned             sel;
  int unsigned             idx;
  logic [N_CHANNELS-1:0]   rot;

  // Concatenating req with itself lets a plain right shift act as a rotate,
  // so bit 0 of rot is the channel just after last_ptr.
  always_comb begin
    start = 32'(last_ptr) + 32'd1;
    if (start >= 32'(N_CHANNELS)) start = 32'd0;
    rot = N_CHANNELS'({req, req} >> start);
    sel = 32'd0;
    for (int k = N_CHANNELS - 1; k >= 0; k--) begin
      if (rot[k]) sel = 32'(k);
    end
    idx = start + sel;
    if (idx >= 32'(N_CHANNELS)) idx = idx - 32'(N_CHANNELS);
    found    = |req;
    next_idx = P_CHAN_WIDTH'(idx);
  end

endmodule

// File: rtl/wvb_rdout_arbiter.sv
// wvb_rdout_arbiter: round-robin scheduler sharing the waveform-buffer reader
// among N_CHANNELS acquisition channels.
//   clk, rst_n         clock, async active-low reset
//   en                 arbiter enable
//   chan_mask          1 = channel eligible
//   hdr_empty          per-channel header FIFO empty
//   grant_valid        grant offered (OFFER state)
//   grant_chan         granted channel index
//   grant_onehot       one-hot of grant_chan while offering or busy
//   grant_ack          reader accepts the offer
//   rd_done            reader finished the waveform (pulse)
//   to_limit           ACTIVE cycle limit, 0 disables timeout
//   busy               ACTIVE state
//   to_flag / to_clr   sticky timeout flag and its clear
//   n_grants           accepted grant count (wraps)
module wvb_rdout_arbiter
  import wvb_arb_pkg::*;
#(
  parameter int N_CHANNELS   = 24,
  parameter int P_CHAN_WIDTH = P_CHAN_WIDTH_DEF,
  parameter int P_TO_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_CHANNELS-1:0]   chan_mask,
  input  logic [N_CHANNELS-1:0]   hdr_empty,
  output logic                    grant_valid,
  output logic [P_CHAN_WIDTH-1:0] grant_chan,
  output logic [N_CHANNELS-1:0]   grant_onehot,
  input  logic                    grant_ack,
  input  logic                    rd_done,
  input  logic [P_TO_WIDTH-1:0]   to_limit,
  output logic                    busy,
  output logic                    to_flag,
  input  logic                    to_clr,
  output logic [31:0]             n_grants
);

  arb_state_e              state_q, state_d;
  logic                    grant_valid_q, grant_valid_d;
  logic [P_CHAN_WIDTH-1:0] grant_chan_q, grant_chan_d;
  logic [N_CHANNELS-1:0]   grant_onehot_q, grant_onehot_d;
  logic                    busy_q, busy_d;
  logic                    to_flag_q, to_flag_d;
  logic [31:0]             n_grants_q, n_grants_d;
  logic [P_TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
  logic [P_CHAN_WIDTH-1:0] last_ptr_q, last_ptr_d;

  logic [N_CHANNELS-1:0]   req;
  logic                    found;
  logic [P_CHAN_WIDTH-1:0] next_idx;

  assign req = ~hdr_empty & chan_mask;

  rr_priority_select #(
    .N_CHANNELS  (N_CHANNELS),
    .P_CHAN_WIDTH(P_CHAN_WIDTH)
  ) u_sel (
    .req     (req),
    .last_ptr(last_ptr_q),
    .found   (found),
    .next_idx(next_idx)
  );

  always_comb begin
    state_d        = state_q;
    grant_valid_d  = grant_valid_q;
    grant_chan_d   = grant_chan_q;
    grant_onehot_d = grant_onehot_q;
    busy_d         = busy_q;
    to_flag_d      = to_flag_q;
    n_grants_d     = n_grants_q;
    to_cnt_d       = to_cnt_q;
    last_ptr_d     = last_ptr_q;

    // Clear is applied first so a timeout in the same cycle overrides it.
    if (to_clr) to_flag_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en && found) begin
          state_d        = ST_OFFER;
          grant_valid_d  = 1'b1;
          grant_chan_d   = next_idx;
          grant_onehot_d = N_CHANNELS'(idx_to_onehot(32'(next_idx)));
        end
      end
      ST_OFFER: begin
        // Ack has priority over a simultaneous enable drop.
        if (grant_ack) begin
          state_d       = ST_ACTIVE;
          grant_valid_d = 1'b0;
          busy_d        = 1'b1;
          last_ptr_d    = grant_chan_q;
          n_grants_d    = n_grants_q + 32'd1;
          to_cnt_d      = P_TO_WIDTH'(1);
        end else if (!en) begin
          state_d        = ST_IDLE;
          grant_valid_d  = 1'b0;
          grant_onehot_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (rd_done) begin
          state_d        = ST_HOLDOFF;
          busy_d         = 1'b0;
          grant_onehot_d = '0;
        end else if ((to_limit != '0) && (to_cnt_q == to_limit)) begin
          state_d        = ST_HOLDOFF;
          busy_d         = 1'b0;
          grant_onehot_d = '0;
          to_flag_d      = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + P_TO_WIDTH'(1);
        end
      end
      ST_HOLDOFF: begin
        // One idle cycle lets hdr_empty catch up with the completed read.
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      grant_valid_q  <= 1'b0;
      grant_chan_q   <= '0;
      grant_onehot_q <= '0;
      busy_q         <= 1'b0;
      to_flag_q      <= 1'b0;
      n_grants_q     <= '0;
      to_cnt_q       <= '0;
      last_ptr_q     <= P_CHAN_WIDTH'(N_CHANNELS - 1);
    end else begin
      state_q        <= state_d;
      grant_valid_q  <= grant_valid_d;
      grant_chan_q   <= grant_chan_d;
      grant_onehot_q <= grant_onehot_d;
      busy_q         <= busy_d;
      to_flag_q      <= to_flag_d;
      n_grants_q     <= n_grants_d;
      to_cnt_q       <= to_cnt_d;
      last_ptr_q     <= last_ptr_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_chan   = grant_chan_q;
  assign grant_onehot = grant_onehot_q;
  assign busy         = busy_q;
  assign to_flag      = to_flag_q;
  assign n_grants     = n_grants_q;

endmodule

// File: tb/tb_wvb_rdout_arbiter.sv
module tb_wvb_rdout_arbiter;

  localparam int N  = 24;
  localparam int CW = 5;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  chan_mask;
  logic [N-1:0]  hdr_empty;
  logic          grant_valid;
  logic [CW-1:0] grant_chan;
  logic [N-1:0]  grant_onehot;
  logic          grant_ack;
  logic          rd_done;
  logic [TW-1:0] to_limit;
  logic          busy;
  logic          to_flag;
  logic          to_clr;
  logic [31:0]   n_grants;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_grants = 0;

  wvb_rdout_arbiter #(
    .N_CHANNELS  (N),
    .P_CHAN_WIDTH(CW),
    .P_TO_WIDTH  (TW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .chan_mask   (chan_mask),
    .hdr_empty   (hdr_empty),
    .grant_valid (grant_valid),
    .grant_chan  (grant_chan),
    .grant_onehot(grant_onehot),
    .grant_ack   (grant_ack),
    .rd_done     (rd_done),
    .to_limit    (to_limit),
    .busy        (busy),
    .to_flag     (to_flag),
    .to_clr      (to_clr),
    .n_grants    (n_grants)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input logic [N-1:0] r);
    hdr_empty = ~r;
  endtask

  int order [5] = '{0, 2, 23, 0, 2};

  initial begin
    rst_n = 1'b0; en = 1'b0; chan_mask = '1; hdr_empty = '1;
    grant_ack = 1'b0; rd_done = 1'b0; to_limit = '0; to_clr = 1'b0;
    cyc(2);
    check("rst_gv", grant_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_chan", grant_chan, 0);
    check("rst_oh", grant_onehot, 0);
    check("rst_flag", to_flag, 0);
    check("rst_ngr", n_grants, 0);

    // Single channel 0 transaction
    rst_n = 1'b1; en = 1'b1; set_req(24'h000001);
    cyc(1);
    check("t1_gv", grant_valid, 1);
    check("t1_chan", grant_chan, 0);
    check("t1_oh", grant_onehot, 32'h1);
    grant_ack = 1'b1;
    cyc(1);
    grant_ack = 1'b0; exp_grants++;
    check("t1_busy", busy, 1);
    check("t1_gv_off", grant_valid, 0);
    check("t1_ngr", n_grants, exp_grants);
    check("t1_oh_act", grant_onehot, 32'h1);
    rd_done = 1'b1; set_req('0);
    cyc(1);
    rd_done = 1'b0;
    check("t1_hold_busy", busy, 0);
    check("t1_hold_oh", grant_onehot, 0);
    cyc(1);
    check("t1_idle_gv", grant_valid, 0);
    check("t1_idle_ngr", n_grants, 1);

    // Round robin over channels 0, 2, 23 from a fresh reset
    rst_n = 1'b0; exp_grants = 0;
    cyc(1);
    rst_n = 1'b1; set_req(24'h800005);
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr%0d_gv", i), grant_valid, 1);
      check($sformatf("rr%0d_chan", i), grant_chan, order[i]);
      grant_ack = 1'b1;
      cyc(1);
      grant_ack = 1'b0; exp_grants++;
      check($sformatf("rr%0d_busy", i), busy, 1);
      rd_done = 1'b1;
      if (i == 4) set_req('0);
      cyc(1);
      rd_done = 1'b0;
      check($sformatf("rr%0d_hold_gv", i), grant_valid, 0);
      cyc(1);
      check($sformatf("rr%0d_idle_gv", i), grant_valid, 0);
      cyc(1);
    end
    check("rr_end_gv", grant_valid, 0);
    check("rr_ngr", n_grants, exp_grants);

    // Masking: channel 0 masked, then unmasked
    chan_mask = 24'hFFFFFE; set_req(24'h000003);
    cyc(1);
    check("mask_gv", grant_valid, 1);
    check("mask_chan", grant_chan, 1);
    grant_ack = 1'b1;
    cyc(1);
    grant_ack = 1'b0; exp_grants++;
    rd_done = 1'b1; chan_mask = '1;
    cyc(1);
    rd_done = 1'b0;
    cyc(2);
    check("unmask_gv", grant_valid, 1);
    check("unmask_chan", grant_chan, 0);
    grant_ack = 1'b1;
    cyc(1);
    grant_ack = 1'b0; exp_grants++;
    rd_done = 1'b1; set_req('0);
    cyc(1);
    rd_done = 1'b0;
    cyc(2);

    // Timeout with limit 5
    to_limit = 16'd5; set_req(24'h000010);
    cyc(1);
    check("to_chan", grant_chan, 4);
    grant_ack = 1'b1;
    cyc(1);
    grant_ack = 1'b0; exp_grants++; set_req('0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("to_busy%0d", k + 1), busy, 1);
      check($sformatf("to_flag_lo%0d", k + 1), to_flag, 0);
      cyc(1);
    end
    check("to_busy_end", busy, 0);
    check("to_flag_set", to_flag, 1);
    cyc(1);
    check("to_idle_gv", grant_valid, 0);
    check("to_flag_sticky", to_flag, 1);
    to_clr = 1'b1;
    cyc(1);
    to_clr = 1'b0;
    check("to_flag_clr", to_flag, 0);

    // Timeout disabled
    to_limit = '0; set_req(24'h000010);
    cyc(1);
    check("nto_chan", grant_chan, 4);
    grant_ack = 1'b1;
    cyc(1);
    grant_ack = 1'b0; exp_grants++; set_req('0);
    cyc(40);
    check("nto_busy", busy, 1);
    check("nto_flag", to_flag, 0);
    rd_done = 1'b1;
    cyc(1);
    rd_done = 1'b0;
    check("nto_done", busy, 0);
    cyc(2);

    // Enable drop during OFFER, then ack with en low
    set_req(24'h000090);
    cyc(1);
    check("en_gv", grant_valid, 1);
    check("en_chan", grant_chan, 7);
    en = 1'b0;
    cyc(1);
    check("en_withdraw_gv", grant_valid, 0);
    check("en_withdraw_oh", grant_onehot, 0);
    en = 1'b1;
    cyc(1);
    check("en_regrant_gv", grant_valid, 1);
    check("en_regrant_chan", grant_chan, 7);
    check("en_regrant_oh", grant_onehot, 32'h80);
    grant_ack = 1'b1; en = 1'b0;
    cyc(1);
    grant_ack = 1'b0; exp_grants++;
    check("ackwin_busy", busy, 1);
    check("ackwin_ngr", n_grants, exp_grants);
    cyc(2);
    check("en_no_abort", busy, 1);
    rd_done = 1'b1; set_req('0);
    cyc(1);
    rd_done = 1'b0; en = 1'b1;
    cyc(2);

    // Asynchronous reset mid-ACTIVE
    set_req(24'h000200);
    cyc(1);
    check("ar_chan", grant_chan, 9);
    grant_ack = 1'b1;
    cyc(1);
    grant_ack = 1'b0;
    check("ar_busy", busy, 1);
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy0", busy, 0);
    check("ar_gv0", grant_valid, 0);
    check("ar_chan0", grant_chan, 0);
    check("ar_oh0", grant_onehot, 0);
    check("ar_ngr0", n_grants, 0);
    check("ar_flag0", to_flag, 0);
    @(negedge clk);
    rst_n = 1'b1; set_req(24'h000201);
    cyc(1);
    check("ar_prio_gv", grant_valid, 1);
    check("ar_prio_chan", grant_chan, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
